std_gray_counter: RTL and testbench

- Registered binary/Gray up/down counter; the encoding counterpart to the Gray-to-binary decoder.
- Main use: read/write pointer generator for async FIFOs and CDC paths.
- Flopped Gray output crosses clock domains glitch-free: exactly one bit toggles per count step.
- Also exposes the binary value and a combinational next-Gray value for full/empty compare logic.

---
 rtl/std_pkg.sv | 42 ++++
 rtl/std_bin2gray.sv | 28 ++
 rtl/std_gray_counter.sv | 148 ++++++++++++++
 tb/tb_std_gray_counter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_pkg.sv
// ---------------------------------------------------------------------------
// std_pkg
// Shared definitions for the std_* counter / code-conversion blocks.
//
// Contents:
//   GRAY_MAX_W  - widest value the generic bin2gray helper handles
//   count_op_t  - decoded count request (HOLD / UP / DOWN)
//   bin2gray()  - binary to reflected Gray encoding, width-generic
//   decode_op() - folds the raw inc/dec request pair into a count_op_t
// ---------------------------------------------------------------------------
package std_pkg;

  // Callers zero-extend their DW-bit value up to this width and truncate the
  // result back down. Zero-extension keeps the top Gray bit correct, because
  // the implicit bit above the MSB is zero.
  localparam int GRAY_MAX_W = 64;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } count_op_t;

  // Reflected binary Gray code: each Gray bit is the XOR of the matching
  // binary bit and the bit above it.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] value);
    return value ^ (value >> 1);
  endfunction

  // Conflicting requests (both inc and dec) cancel out to a hold.
  function automatic count_op_t decode_op(input logic inc, input logic dec);
    count_op_t op;
    op = HOLD;
    if (inc && !dec) begin
      op = UP;
    end else if (dec && !inc) begin
      op = DOWN;
    end
    return op;
  endfunction

endpackage

// File: rtl/std_bin2gray.sv
// ---------------------------------------------------------------------------
// std_bin2gray
// Purely combinational binary-to-Gray encoder, usable wherever a Gray
// encoding is needed (pointer generators, CDC snapshots, etc).
//
// Parameters:
//   DW      - data width in bits (2 .. GRAY_MAX_W)
// Ports:
//   bin_i   - input  [DW-1:0]  binary value
//   gray_o  - output [DW-1:0]  reflected Gray encoding of bin_i
// ---------------------------------------------------------------------------
module std_bin2gray
  import std_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0] bin_i,
  output logic [DW-1:0] gray_o
);

  if (DW < 2 || DW > GRAY_MAX_W) begin : g_bad_dw
    $error("std_bin2gray: DW must be between 2 and GRAY_MAX_W");
  end

  // Widen to the package helper width and narrow the result back down.
  assign gray_o = DW'(bin2gray(GRAY_MAX_W'(bin_i)));

endmodule

// File: rtl/std_gray_counter.sv
// ---------------------------------------------------------------------------
// std_gray_counter
// Registered binary/Gray up/down counter, intended as the read/write pointer
// generator of an async FIFO. The Gray output comes straight from a flop, so
// a count step toggles exactly one bit and can be sampled safely from another
// clock domain. Loads may change several Gray bits; the caller owns CDC
// safety around loads.
//
// Parameters:
//   DW        - counter width in bits (>= 2)
//   WRAP      - 1: modulo 2^DW wrap-around, 0: saturate at all-ones / zero
//   RST_VAL   - binary value used on reset and clear
// Ports:
//   clk       - input             clock, all state changes on rising edge
//   nreset    - input             synchronous reset, active-low
//   clear     - input             synchronous return to RST_VAL
//   load      - input             load load_bin this cycle
//   load_bin  - input  [DW-1:0]   binary value to load
//   inc       - input             count up request
//   dec       - input             count down request
//   bin       - output [DW-1:0]   registered binary count
//   gray      - output [DW-1:0]   registered Gray encoding of bin
//   gray_next - output [DW-1:0]   combinational Gray encoding of next bin
//   wrap      - output            one-cycle pulse after a wrap step (WRAP=1)
//   sat       - output            held at a limit, request refused (WRAP=0)
// Priority each cycle: nreset > clear > load > count.
// ---------------------------------------------------------------------------
module std_gray_counter
  import std_pkg::*;
#(
  parameter int            DW      = 4,
  parameter bit            WRAP    = 1'b1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] load_bin,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] bin,
  output logic [DW-1:0] gray,
  output logic [DW-1:0] gray_next,
  output logic          wrap,
  output logic          sat
);

  if (DW < 2) begin : g_bad_dw
    $error("std_gray_counter: DW must be at least 2");
  end

  localparam logic [DW-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);
  localparam logic [DW-1:0] ALL_ONES = '1;
  localparam logic [DW-1:0] ONE      = DW'(1);

  logic [DW-1:0] bin_q, bin_d;
  logic [DW-1:0] gray_q;
  logic          wrap_q, wrap_d;
  logic          sat_q, sat_d;

  count_op_t     count_op;
  logic          at_max;
  logic          at_min;

  assign count_op = decode_op(inc, dec);
  assign at_max   = (bin_q == ALL_ONES);
  assign at_min   = (bin_q == '0);

  // Next-state logic for the binary count and the wrap/sat flags. Reset is
  // folded in here as well so that gray_next always matches what the gray
  // register is about to hold, including during reset. A held cycle drops
  // wrap but leaves sat alone, so a refused request stays flagged until
  // something moves the counter. With WRAP=1 the sat branch is never taken,
  // so sat stays at its reset value of zero; with WRAP=0 wrap is never set.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    if (!nreset || clear) begin
      bin_d = RST_VAL;
      sat_d = 1'b0;
    end else if (load) begin
      bin_d = load_bin;
      sat_d = 1'b0;
    end else begin
      case (count_op)
        UP: begin
          if (!at_max) begin
            bin_d = bin_q + ONE;
            sat_d = 1'b0;
          end else if (WRAP) begin
            bin_d  = '0;
            wrap_d = 1'b1;
            sat_d  = 1'b0;
          end else begin
            sat_d = 1'b1;
          end
        end
        DOWN: begin
          if (!at_min) begin
            bin_d = bin_q - ONE;
            sat_d = 1'b0;
          end else if (WRAP) begin
            bin_d  = ALL_ONES;
            wrap_d = 1'b1;
            sat_d  = 1'b0;
          end else begin
            sat_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Single encoder on the next-state value; the gray flop loads its output,
  // which keeps bin and gray coherent in every cycle.
  std_bin2gray #(
    .DW(DW)
  ) u_bin2gray (
    .bin_i  (bin_d),
    .gray_o (gray_next)
  );

  // State register. The synchronous reset is repeated here explicitly so the
  // flops have a direct reset branch even though bin_d already honours it.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      bin_q  <= RST_VAL;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_next;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_std_gray_counter.sv
// ---------------------------------------------------------------------------
// tb_std_gray_counter
// Drives three counter flavours with one shared stimulus stream:
//   0: WRAP=1, RST_VAL=0   1: WRAP=0, RST_VAL=0   2: WRAP=1, RST_VAL=6
// An integer model plus a Gray table built by reflection predict every output.
// ---------------------------------------------------------------------------
module tb_std_gray_counter;

  localparam int DW   = 4;
  localparam int NDUT = 3;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  logic nreset, clear, load, inc, dec;
  logic [DW-1:0] load_bin;

  logic [DW-1:0] dBin [NDUT];
  logic [DW-1:0] dGray [NDUT];
  logic [DW-1:0] dGrayNext [NDUT];
  logic          dWrap [NDUT];
  logic          dSat [NDUT];

  int wrapMode [NDUT] = '{1, 0, 1};
  int rstVal [NDUT]   = '{0, 0, 6};

  int grayTable [16];
  int mBin [NDUT];
  bit mWrap [NDUT];
  bit mSat [NDUT];
  bit mStepped [NDUT];
  bit modelValid = 1'b0;
  bit prevValid = 1'b0;
  logic [DW-1:0] prevGray [NDUT];

  int assertCount = 0;
  int failCount = 0;

  int expUpGray [20] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0, 1, 3, 2, 6};
  int expDnBin [3]   = '{0, 15, 14};
  int expDnGray [3]  = '{0, 8, 9};
  int expDnWrap [3]  = '{0, 1, 0};

  always #5 clk = ~clk;

  std_gray_counter #(.DW(DW), .WRAP(1'b1), .RST_VAL(4'd0)) u_dut_wrap (
    .clk(clk), .nreset(nreset), .clear(clear), .load(load), .load_bin(load_bin),
    .inc(inc), .dec(dec), .bin(dBin[0]), .gray(dGray[0]), .gray_next(dGrayNext[0]),
    .wrap(dWrap[0]), .sat(dSat[0]));

  std_gray_counter #(.DW(DW), .WRAP(1'b0), .RST_VAL(4'd0)) u_dut_sat (
    .clk(clk), .nreset(nreset), .clear(clear), .load(load), .load_bin(load_bin),
    .inc(inc), .dec(dec), .bin(dBin[1]), .gray(dGray[1]), .gray_next(dGrayNext[1]),
    .wrap(dWrap[1]), .sat(dSat[1]));

  std_gray_counter #(.DW(DW), .WRAP(1'b1), .RST_VAL(4'd6)) u_dut_rst6 (
    .clk(clk), .nreset(nreset), .clear(clear), .load(load), .load_bin(load_bin),
    .inc(inc), .dec(dec), .bin(dBin[2]), .gray(dGray[2]), .gray_next(dGrayNext[2]),
    .wrap(dWrap[2]), .sat(dSat[2]));

  // Reflected Gray sequence: each doubling mirrors the existing list and sets
  // the new top bit on the mirrored half.
  initial begin
    grayTable[0] = 0;
    grayTable[1] = 1;
    for (int w = 2; w <= DW; w++) begin
      for (int k = (1 << (w - 1)); k < (1 << w); k++) begin
        grayTable[k] = grayTable[(1 << w) - 1 - k] | (1 << (w - 1));
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic nres, input logic clr, input logic ld,
                               input int lb, input logic up, input logic dn);
    nreset   = nres;
    clear    = clr;
    load     = ld;
    load_bin = 4'(lb);
    inc      = up;
    dec      = dn;
  endtask

  task automatic tickClock();
    @(posedge clk);
    #2;
  endtask

  // Counter rules in plain integer arithmetic, using the current inputs.
  function automatic void modelNext(input int i, input int cur, input bit curSat,
                                    output int nb, output bit w, output bit s, output bit st);
    int target;
    nb = cur;
    w  = 1'b0;
    s  = curSat;
    st = 1'b0;
    if (!nreset || clear) begin
      nb = rstVal[i];
      s  = 1'b0;
    end else if (load) begin
      nb = int'(load_bin);
      s  = 1'b0;
    end else if (inc !== dec) begin
      target = cur + (inc ? 1 : -1);
      if (target >= 0 && target <= MAXV) begin
        nb = target;
        s  = 1'b0;
        st = 1'b1;
      end else if (wrapMode[i] == 1) begin
        nb = (target + MAXV + 1) % (MAXV + 1);
        w  = 1'b1;
        s  = 1'b0;
        st = 1'b1;
      end else begin
        s = 1'b1;
      end
    end
  endfunction

  // Model advances on every rising edge, alongside the DUT flops.
  always @(posedge clk) begin
    int nb;
    bit w, s, st;
    for (int i = 0; i < NDUT; i++) begin
      modelNext(i, mBin[i], mSat[i], nb, w, s, st);
      mBin[i]     = nb;
      mWrap[i]    = w;
      mSat[i]     = s;
      mStepped[i] = st;
    end
    if (!nreset) modelValid = 1'b1;
  end

  // Cycle-by-cycle comparison on the falling edge, when everything is settled.
  always @(negedge clk) begin
    int nb;
    bit w, s, st;
    if (modelValid) begin
      for (int i = 0; i < NDUT; i++) begin
        checkOutput($sformatf("bin[%0d]", i), 32'(dBin[i]), 32'(mBin[i]));
        checkOutput($sformatf("gray[%0d]", i), 32'(dGray[i]), 32'(grayTable[mBin[i]]));
        checkOutput($sformatf("wrap[%0d]", i), 32'(dWrap[i]), 32'(mWrap[i]));
        checkOutput($sformatf("sat[%0d]", i), 32'(dSat[i]), 32'(mSat[i]));
        modelNext(i, mBin[i], mSat[i], nb, w, s, st);
        checkOutput($sformatf("gray_next[%0d]", i), 32'(dGrayNext[i]), 32'(grayTable[nb]));
        if (prevValid && mStepped[i]) begin
          checkOutput($sformatf("gray_onebit[%0d]", i), 32'($countones(dGray[i] ^ prevGray[i])), 32'd1);
        end
        prevGray[i] = dGray[i];
      end
      prevValid = 1'b1;
    end
  end

  initial begin
    int mode;
    int r;
    int lb;
    logic up, dn;

    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) begin
      tickClock();
      checkOutput("rst_bin", 32'(dBin[0]), 32'd0);
      checkOutput("rst_gray", 32'(dGray[0]), 32'd0);
      checkOutput("rst6_bin", 32'(dBin[2]), 32'd6);
      checkOutput("rst6_gray", 32'(dGray[2]), 32'd5);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tickClock();
      checkOutput("up_bin", 32'(dBin[0]), 32'(k % 16));
      checkOutput("up_gray", 32'(dGray[0]), 32'(expUpGray[k - 1]));
      checkOutput("up_wrap", 32'(dWrap[0]), (k == 16) ? 32'd1 : 32'd0);
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    tickClock();
    checkOutput("load1_bin", 32'(dBin[0]), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tickClock();
      checkOutput("dn_bin", 32'(dBin[0]), 32'(expDnBin[k]));
      checkOutput("dn_gray", 32'(dGray[0]), 32'(expDnGray[k]));
      checkOutput("dn_wrap", 32'(dWrap[0]), 32'(expDnWrap[k]));
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    tickClock();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    tickClock();
    checkOutput("both_hold_bin", 32'(dBin[0]), 32'd5);
    checkOutput("both_hold_gray", 32'(dGray[0]), 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, 12, 1'b1, 1'b0);
    tickClock();
    checkOutput("load_over_inc_bin", 32'(dBin[0]), 32'd12);
    checkOutput("load_over_inc_gray", 32'(dGray[0]), 32'd10);
    applyStimulus(1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b0);
    tickClock();
    checkOutput("clear_over_load_bin", 32'(dBin[0]), 32'd0);
    checkOutput("clear_over_load_rst6", 32'(dBin[2]), 32'd6);

    applyStimulus(1'b1, 1'b0, 1'b1, 15, 1'b0, 1'b0);
    tickClock();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (2) begin
      tickClock();
      checkOutput("sat_hi_bin", 32'(dBin[1]), 32'd15);
      checkOutput("sat_hi_gray", 32'(dGray[1]), 32'd8);
      checkOutput("sat_hi_flag", 32'(dSat[1]), 32'd1);
      checkOutput("sat_hi_nowrap", 32'(dWrap[1]), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    tickClock();
    checkOutput("sat_release_bin", 32'(dBin[1]), 32'd14);
    checkOutput("sat_release_flag", 32'(dSat[1]), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    tickClock();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    tickClock();
    checkOutput("sat_lo_bin", 32'(dBin[1]), 32'd0);
    checkOutput("sat_lo_flag", 32'(dSat[1]), 32'd1);
    checkOutput("wrap_lo_bin", 32'(dBin[0]), 32'd15);
    checkOutput("wrap_lo_sat", 32'(dSat[0]), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b0);
    tickClock();
    checkOutput("mid_load_bin", 32'(dBin[0]), 32'd9);
    applyStimulus(1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0);
    tickClock();
    checkOutput("mid_rst_bin", 32'(dBin[0]), 32'd0);
    checkOutput("mid_rst_wrap", 32'(dWrap[0]), 32'd0);
    checkOutput("mid_rst_sat", 32'(dSat[1]), 32'd0);
    checkOutput("mid_rst6_bin", 32'(dBin[2]), 32'd6);
    checkOutput("mid_rst6_gray", 32'(dGray[2]), 32'd5);

    applyStimulus(1'b1, 1'b0, 1'b1, 7, 1'b0, 1'b0);
    tickClock();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    #1;
    checkOutput("gray_next_comb", 32'(dGrayNext[0]), 32'd12);
    tickClock();
    checkOutput("gray_next_reg", 32'(dGray[0]), 32'd12);
    checkOutput("gray_next_bin", 32'(dBin[0]), 32'd8);

    // Random run: direction modes persist for a while so the limits get hit.
    mode = 0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 39) == 0) mode = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 3));
      lb = (r == 0) ? 15 : (r == 1) ? 0 : int'($urandom_range(0, 15));
      case (mode)
        0: begin
          up = ($urandom_range(0, 9) != 0);
          dn = ($urandom_range(0, 9) == 0);
        end
        1: begin
          up = ($urandom_range(0, 9) == 0);
          dn = ($urandom_range(0, 9) != 0);
        end
        default: begin
          up = 1'($urandom_range(0, 1));
          dn = 1'($urandom_range(0, 1));
        end
      endcase
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 29) == 0), lb, up, dn);
      tickClock();
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tickClock();
    tickClock();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
